// File: rtl/aes192_encrypt_iter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes192_encrypt_iter_if : request/response bundle for the AES-192 core
// Revision: 1.0
// ----------------------------------------------------------------------------
interface aes192_encrypt_iter_if;
   logic         start;
   logic [191:0] key_in;
   logic [127:0] data_in;
   logic         busy;
   logic         done;
   logic [127:0] data_out;

   modport master (output start, key_in, data_in, input busy, done, data_out);
   modport slave  (input start, key_in, data_in, output busy, done, data_out);
endinterface
`default_nettype wire

// File: rtl/aes192_encrypt_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes192_encrypt_iter : iterative AES-192 encryption, one round per clock,
//                       key schedule expanded on the fly (two 192-bit blocks)
// Revision: 1.0
// ----------------------------------------------------------------------------
module aes192_encrypt_iter (
   input  wire                  clk,
   input  wire                  rst,
   aes192_encrypt_iter_if.slave bus
);

   localparam logic [2047:0] c_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return c_SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte b of the state sits at bits [127-8b -: 8], b = row + 4*col.
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // One six-word step of the AES-192 key schedule.
   function automatic logic [191:0] key_expansion192(input logic [191:0] k,
                                                     input logic [7:0]   rc);
      logic [31:0] t, n0, n1, n2, n3, n4, n5;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n0 = k[191:160] ^ t;
      n1 = k[159:128] ^ n0;
      n2 = k[127:96]  ^ n1;
      n3 = k[95:64]   ^ n2;
      n4 = k[63:32]   ^ n3;
      n5 = k[31:0]    ^ n4;
      return {n0, n1, n2, n3, n4, n5};
   endfunction

   state_e       state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   phase_q, phase_d;
   logic [7:0]   rcon_q, rcon_d;
   logic [191:0] ka_q, ka_d, kb_q, kb_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] dout_q, dout_d;
   logic         done_q, done_d;

   logic [127:0] w_rk;
   logic [191:0] w_xin, w_xout;
   logic [7:0]   w_xrcon;
   logic [127:0] w_sub_shift, w_mix;

   // ka holds K(2j), kb holds K(2j+1); phase = round mod 3 picks the slice.
   always_comb begin
      case (phase_q)
         2'd1:    w_rk = {ka_q[63:0], kb_q[191:128]};
         2'd2:    w_rk = kb_q[127:0];
         default: w_rk = ka_q[191:64];
      endcase
   end

   assign w_xin       = (state_q == ST_IDLE) ? bus.key_in : ((phase_q == 2'd2) ? kb_q : ka_q);
   assign w_xrcon     = (state_q == ST_IDLE) ? 8'h01 : rcon_q;
   assign w_xout      = key_expansion192(w_xin, w_xrcon);
   assign w_sub_shift = sub_shift(blk_q);
   assign w_mix       = mix_columns(w_sub_shift);

   always_comb begin
      state_d = state_q;
      round_d = round_q;
      phase_d = phase_q;
      rcon_d  = rcon_q;
      ka_d    = ka_q;
      kb_d    = kb_q;
      blk_d   = blk_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_RUN;
               blk_d   = bus.data_in ^ bus.key_in[191:64];
               round_d = 4'd1;
               phase_d = 2'd1;
               ka_d    = bus.key_in;
               kb_d    = w_xout;
               rcon_d  = 8'h02;
            end
         end
         default: begin
            if (round_q == 4'd12) begin
               dout_d  = w_sub_shift ^ w_rk;
               done_d  = 1'b1;
               state_d = ST_IDLE;
               round_d = 4'd0;
               phase_d = 2'd0;
            end else begin
               blk_d   = w_mix ^ w_rk;
               round_d = round_q + 4'd1;
               phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
               if (phase_q == 2'd2) begin
                  ka_d   = w_xout;
                  rcon_d = xtime(rcon_q);
               end else if (phase_q == 2'd0) begin
                  kb_d   = w_xout;
                  rcon_d = xtime(rcon_q);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         round_q <= 4'd0;
         phase_q <= 2'd0;
         rcon_q  <= 8'h0;
         ka_q    <= '0;
         kb_q    <= '0;
         blk_q   <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         phase_q <= phase_d;
         rcon_q  <= rcon_d;
         ka_q    <= ka_d;
         kb_q    <= kb_d;
         blk_q   <= blk_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy     = (state_q == ST_RUN);
   assign bus.done     = done_q;
   assign bus.data_out = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_aes192_encrypt_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes192_encrypt_iter : known-answer vectors, protocol corner cases and
//                          random blocks against an FIPS-197 reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_aes192_encrypt_iter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes192_encrypt_iter_if bus ();
   aes192_encrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] sb  [256];
   logic [7:0] isb [256];

   typedef struct {
      logic [191:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
   } vec_t;

   localparam logic [191:0] c_C2_KEY = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] c_C2_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] c_C2_CT  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] c_Z_CT   = 128'haae06992acbf52a3e8f4a96ec9300bd7;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s, v8;
      for (int v = 0; v < 256; v++) begin
         v8  = v[7:0];
         inv = 8'h01;
         for (int k = 0; k < 254; k++) inv = gmul(inv, v8);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sb[v]  = s;
         isb[s] = v8;
      end
   endtask

   function automatic void expand(input logic [191:0] key, output logic [31:0] w [52]);
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 6; i++) w[i] = key[191-32*i -: 32];
      for (int i = 6; i < 52; i++) begin
         t = w[i-1];
         if (i % 6 == 0) begin
            t  = {t[23:0], t[31:24]};
            t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-6] ^ t;
      end
   endfunction

   function automatic logic [127:0] model_enc(input logic [191:0] key, input logic [127:0] pt);
      logic [31:0] w [52];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [127:0] r;
      expand(key, w);
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 12; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[row+4*c] = sb[s[row+4*((c+row)%4)]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < 12) begin
               s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
               s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
            end else begin
               for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   // Inverse cipher: stands in for the downstream decryptor in the round trip.
   function automatic logic [127:0] model_dec(input logic [191:0] key, input logic [127:0] ct);
      logic [31:0] w [52];
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [127:0] r;
      expand(key, w);
      for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[48 + i/4][31-8*(i%4) -: 8];
      for (int rnd = 11; rnd >= 0; rnd--) begin
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               t[row+4*((c+row)%4)] = s[row+4*c];
         for (int i = 0; i < 16; i++) t[i] = isb[t[i]] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
         for (int c = 0; c < 4; c++) begin
            if (rnd > 0) begin
               s[4*c]   = gmul(8'h0e, t[4*c]) ^ gmul(8'h0b, t[4*c+1]) ^ gmul(8'h0d, t[4*c+2]) ^ gmul(8'h09, t[4*c+3]);
               s[4*c+1] = gmul(8'h09, t[4*c]) ^ gmul(8'h0e, t[4*c+1]) ^ gmul(8'h0b, t[4*c+2]) ^ gmul(8'h0d, t[4*c+3]);
               s[4*c+2] = gmul(8'h0d, t[4*c]) ^ gmul(8'h09, t[4*c+1]) ^ gmul(8'h0e, t[4*c+2]) ^ gmul(8'h0b, t[4*c+3]);
               s[4*c+3] = gmul(8'h0b, t[4*c]) ^ gmul(8'h0d, t[4*c+1]) ^ gmul(8'h09, t[4*c+2]) ^ gmul(8'h0e, t[4*c+3]);
            end else begin
               for (int row = 0; row < 4; row++) s[4*c+row] = t[4*c+row];
            end
         end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [191:0] k, input logic [127:0] p);
      @(negedge clk);
      bus.start   = s;
      bus.key_in  = k;
      bus.data_in = p;
   endtask

   task automatic do_block(input logic [191:0] k, input logic [127:0] p,
                           input logic [127:0] exp, input string name);
      logic ok;
      ok = 1'b1;
      drive(1'b1, k, p);
      tick();
      bus.start = 1'b0;
      for (int e = 0; e < 12; e++) begin
         if (e > 0) tick();
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
      end
      chk({name, " busy window"}, ok, 1);
      tick();
      chk({name, " done at E12"}, bus.done, 1);
      chk({name, " busy low at E12"}, bus.busy, 0);
      chk({name, " data_out"}, bus.data_out, exp);
      tick();
      chk({name, " done one cycle"}, bus.done, 0);
      chk({name, " data_out held"}, bus.data_out, exp);
   endtask

   // ---------------- test ----------------
   initial begin
      vec_t vecs [2];
      logic [191:0] k;
      logic [127:0] p, exp;
      logic ok;
      int cnt, ndone;

      vecs[0] = '{key: c_C2_KEY, pt: c_C2_PT, ct: c_C2_CT};
      vecs[1] = '{key: 192'h0,   pt: 128'h0,  ct: c_Z_CT};

      build_sbox();

      // reset held together with start: reset must win
      rst = 1'b1;
      bus.start = 1'b1; bus.key_in = c_C2_KEY; bus.data_in = c_C2_PT;
      repeat (3) tick();
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      chk("reset data_out", bus.data_out, 128'h0);
      @(negedge clk);
      rst = 1'b0; bus.start = 1'b0;
      tick();
      chk("idle after reset", bus.busy, 0);

      for (int i = 0; i < 2; i++) do_block(vecs[i].key, vecs[i].pt, vecs[i].ct, $sformatf("vec%0d", i));

      // starts during busy are ignored
      drive(1'b1, c_C2_KEY, c_C2_PT);
      tick();
      bus.start = 1'b0;
      ok = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         drive((e == 3 || e == 11), 192'h0, 128'h0);
         tick();
         if (e < 12 && (bus.done !== 1'b0 || bus.busy !== 1'b1)) ok = 1'b0;
      end
      chk("ignored start window", ok, 1);
      chk("ignored start done", bus.done, 1);
      chk("ignored start data_out", bus.data_out, c_C2_CT);
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.done === 1'b1) ndone++;
      end
      chk("ignored start no second done", ndone, 0);

      // back-to-back: start held high, second vector presented at the done cycle
      drive(1'b1, c_C2_KEY, c_C2_PT);
      ok = 1'b1;
      for (int e = 0; e <= 25; e++) begin
         tick();
         if (e == 12) begin
            chk("b2b first done", bus.done, 1);
            chk("b2b first data_out", bus.data_out, c_C2_CT);
         end
         if (e > 12 && e < 25 && (bus.done !== 1'b0 || bus.data_out !== c_C2_CT || bus.busy !== 1'b1)) ok = 1'b0;
         if (e == 25) begin
            chk("b2b second done", bus.done, 1);
            chk("b2b second data_out", bus.data_out, c_Z_CT);
         end
         if (e == 12) drive(1'b1, 192'h0, 128'h0);
         if (e == 13) drive(1'b0, 192'h0, 128'h0);
      end
      chk("b2b hold window", ok, 1);

      // reset at round 6 aborts the block
      drive(1'b1, c_C2_KEY, c_C2_PT);
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("abort busy", bus.busy, 0);
      chk("abort done", bus.done, 0);
      chk("abort data_out", bus.data_out, 128'h0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (bus.done === 1'b1) ndone++;
      end
      chk("abort no done", ndone, 0);
      do_block(c_C2_KEY, c_C2_PT, c_C2_CT, "after abort");

      // random blocks against the model, with round trip through the inverse
      for (int n = 0; n < 200; n++) begin
         k   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         p   = {$urandom, $urandom, $urandom, $urandom};
         exp = model_enc(k, p);
         drive(1'b1, k, p);
         tick();
         bus.start = 1'b0;
         cnt = 0;
         while (bus.done !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
         end
         chk($sformatf("rand%0d latency", n), cnt, 12);
         chk($sformatf("rand%0d ct", n), bus.data_out, exp);
         chk($sformatf("rand%0d round trip", n), model_dec(k, bus.data_out), p);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
      $fatal(1);
   end

endmodule
`default_nettype wire
